// File: rtl/w_port_rr_arbiter.sv
// West output port arbiter for a NOC router.
// Shares the west port between the north, south, east and local input buffers.
// Inputs request west when valid with a next-hop code of W_DIR_CODE. A
// round-robin pointer picks one winner. The grant is held for the whole packet
// (wormhole) until the tail flit transfers, or until HOLD_MAX cycles pass with
// no transfer, which forces a release.
//
// Ports:
//   clk, reset                  clock, async active-low reset
//   {n,s,e,l}_valid_i           head flit present
//   {n,s,e,l}_nexthop_addr_i    head flit next-hop code
//   {n,s,e,l}_tail_i            head flit is the tail
//   w_ready_i                   west downstream accepts a flit
//   grant_o                     one-hot {n,s,e,l}; zero when idle
//   w_sel_o                     crossbar select n=0 s=1 e=3 l=4 idle=7
//   xfer_o                      flit moves west this cycle
//   rr_change_order_o           one-cycle pulse after any release
//   timeout_o                   one-cycle pulse after a forced release
module w_port_rr_arbiter #(
  parameter int unsigned       ADDR_W     = 3,
  parameter logic [ADDR_W-1:0] W_DIR_CODE = 3'b010,
  parameter int unsigned       HOLD_MAX   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n_valid_i,
  input  logic [ADDR_W-1:0] n_nexthop_addr_i,
  input  logic              n_tail_i,
  input  logic              s_valid_i,
  input  logic [ADDR_W-1:0] s_nexthop_addr_i,
  input  logic              s_tail_i,
  input  logic              e_valid_i,
  input  logic [ADDR_W-1:0] e_nexthop_addr_i,
  input  logic              e_tail_i,
  input  logic              l_valid_i,
  input  logic [ADDR_W-1:0] l_nexthop_addr_i,
  input  logic              l_tail_i,
  input  logic              w_ready_i,
  output logic [3:0]        grant_o,
  output logic [2:0]        w_sel_o,
  output logic              xfer_o,
  output logic              rr_change_order_o,
  output logic              timeout_o
);

  localparam logic [7:0] HoldMax  = 8'(HOLD_MAX);
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        rco_q, rco_d;
  logic        tmo_q, tmo_d;

  // Inputs gathered into vectors indexed n=0, s=1, e=2, l=3.
  logic [3:0]        valid_vec;
  logic [3:0]        tail_vec;
  logic [ADDR_W-1:0] addr_vec [4];
  logic [3:0]        req;

  assign valid_vec   = {l_valid_i, e_valid_i, s_valid_i, n_valid_i};
  assign tail_vec    = {l_tail_i, e_tail_i, s_tail_i, n_tail_i};
  assign addr_vec[0] = n_nexthop_addr_i;
  assign addr_vec[1] = s_nexthop_addr_i;
  assign addr_vec[2] = e_nexthop_addr_i;
  assign addr_vec[3] = l_nexthop_addr_i;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req[k] = valid_vec[k] && (addr_vec[k] == W_DIR_CODE);
    end
  end

  // The granted input must still be aiming west for its flit to move.
  logic xfer;
  assign xfer = (state_q == StGrant) && w_ready_i && req[gnt_idx_q];

  // Round-robin scan starting at ptr_q.
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      gnt_idx_q  <= 2'd0;
      hold_cnt_q <= 8'd0;
      rco_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      rco_q      <= rco_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    rco_d      = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StGrant;
          gnt_idx_d  = win_idx;
          hold_cnt_d = 8'd0;
        end
      end
      StGrant: begin
        if (xfer) begin
          // A transfer beats the timeout threshold.
          hold_cnt_d = 8'd0;
          if (tail_vec[gnt_idx_q]) begin
            state_d = StIdle;
            ptr_d   = gnt_idx_q + 2'd1;
            rco_d   = 1'b1;
          end
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StIdle;
          ptr_d      = gnt_idx_q + 2'd1;
          hold_cnt_d = 8'd0;
          rco_d      = 1'b1;
          tmo_d      = 1'b1;
        end else if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    grant_o = 4'b0000;
    w_sel_o = 3'd7;
    xfer_o  = xfer;
    if (state_q == StGrant) begin
      // grant_o packs n in the MSB.
      grant_o = 4'b1000 >> gnt_idx_q;
      unique case (gnt_idx_q)
        2'd0:    w_sel_o = 3'd0;
        2'd1:    w_sel_o = 3'd1;
        2'd2:    w_sel_o = 3'd3;
        default: w_sel_o = 3'd4;
      endcase
    end
  end

  assign rr_change_order_o = rco_q;
  assign timeout_o         = tmo_q;

endmodule

// File: tb/tb_w_port_rr_arbiter.sv
module tb_w_port_rr_arbiter;

  logic            clk;
  logic            rst_n;
  logic [3:0]      valid;
  logic [3:0]      tail;
  logic [3:0][2:0] addr;
  logic            ready;
  logic [3:0]      grant_o;
  logic [2:0]      w_sel_o;
  logic            xfer_o;
  logic            rco_o;
  logic            tmo_o;

  int errors;
  int checks;

  w_port_rr_arbiter #(
    .ADDR_W    (3),
    .W_DIR_CODE(3'b010),
    .HOLD_MAX  (16)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .n_valid_i        (valid[0]),
    .n_nexthop_addr_i (addr[0]),
    .n_tail_i         (tail[0]),
    .s_valid_i        (valid[1]),
    .s_nexthop_addr_i (addr[1]),
    .s_tail_i         (tail[1]),
    .e_valid_i        (valid[2]),
    .e_nexthop_addr_i (addr[2]),
    .e_tail_i         (tail[2]),
    .l_valid_i        (valid[3]),
    .l_nexthop_addr_i (addr[3]),
    .l_tail_i         (tail[3]),
    .w_ready_i        (ready),
    .grant_o          (grant_o),
    .w_sel_o          (w_sel_o),
    .xfer_o           (xfer_o),
    .rr_change_order_o(rco_o),
    .timeout_o        (tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            rst_n;
    logic [3:0]      valid;
    logic [3:0][2:0] addr;
    logic [3:0]      tail;
    logic            ready;
    logic [3:0]      grant;
    logic [2:0]      sel;
    logic            xfer;
    logic            rco;
    logic            tmo;
  } vec_t;

  localparam logic [11:0] AllW   = {4{3'd2}};
  localparam logic [11:0] LsAddr = {3'd2, 3'd0, 3'd1, 3'd0};
  localparam int          NVec   = 23;

  vec_t tbl [NVec];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [11:0] a, logic [3:0] t, logic rd,
                              logic [3:0] g, logic [2:0] s, logic x, logic c, logic to);
    vec_t m;
    m.rst_n = r;
    m.valid = v;
    m.addr  = a;
    m.tail  = t;
    m.ready = rd;
    m.grant = g;
    m.sel   = s;
    m.xfer  = x;
    m.rco   = c;
    m.tmo   = to;
    return m;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [3:0] g, logic [2:0] s, logic x, logic c,
                         logic to);
    chk({tag, " grant"}, grant_o, g);
    chk({tag, " sel"}, {1'b0, w_sel_o}, {1'b0, s});
    chk({tag, " xfer"}, {3'b0, xfer_o}, {3'b0, x});
    chk({tag, " rco"}, {3'b0, rco_o}, {3'b0, c});
    chk({tag, " timeout"}, {3'b0, tmo_o}, {3'b0, to});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(logic r, logic [3:0] v, logic [11:0] a, logic [3:0] t, logic rd);
    @(negedge clk);
    rst_n = r;
    valid = v;
    addr  = a;
    tail  = t;
    ready = rd;
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, 4'b0000, AllW, 4'b0000, 1'b0);
    drive(1'b1, 4'b0000, AllW, 4'b0000, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    valid  = '0;
    tail   = '0;
    addr   = '0;
    ready  = 1'b0;

    // Round robin over all four inputs with 2-flit packets.
    tbl[0]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 0, 0);
    tbl[1]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b1000, 3'd0, 1, 0, 0);
    tbl[2]  = mk(1, 4'hF, AllW, 4'hF, 1, 4'b1000, 3'd0, 1, 0, 0);
    tbl[3]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[4]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0100, 3'd1, 1, 0, 0);
    tbl[5]  = mk(1, 4'hF, AllW, 4'hF, 1, 4'b0100, 3'd1, 1, 0, 0);
    tbl[6]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[7]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0010, 3'd3, 1, 0, 0);
    tbl[8]  = mk(1, 4'hF, AllW, 4'hF, 1, 4'b0010, 3'd3, 1, 0, 0);
    tbl[9]  = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[10] = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0001, 3'd4, 1, 0, 0);
    tbl[11] = mk(1, 4'hF, AllW, 4'hF, 1, 4'b0001, 3'd4, 1, 0, 0);
    tbl[12] = mk(1, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[13] = mk(1, 4'hF, AllW, 4'h0, 1, 4'b1000, 3'd0, 1, 0, 0);
    // Reset mid-packet, then only l (west) and s (not west) request.
    tbl[14] = mk(0, 4'hF, AllW, 4'h0, 1, 4'b0000, 3'd7, 0, 0, 0);
    tbl[15] = mk(1, 4'hA, LsAddr, 4'h0, 1, 4'b0000, 3'd7, 0, 0, 0);
    tbl[16] = mk(1, 4'hA, LsAddr, 4'h0, 1, 4'b0001, 3'd4, 1, 0, 0);
    tbl[17] = mk(1, 4'hA, LsAddr, 4'hF, 1, 4'b0001, 3'd4, 1, 0, 0);
    tbl[18] = mk(1, 4'hA, LsAddr, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[19] = mk(1, 4'hA, LsAddr, 4'hF, 1, 4'b0001, 3'd4, 1, 0, 0);
    tbl[20] = mk(1, 4'h2, LsAddr, 4'h0, 1, 4'b0000, 3'd7, 0, 1, 0);
    tbl[21] = mk(1, 4'h2, LsAddr, 4'h0, 1, 4'b0000, 3'd7, 0, 0, 0);
    tbl[22] = mk(1, 4'h2, LsAddr, 4'h0, 1, 4'b0000, 3'd7, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 4'b0000, 3'd7, 0, 0, 0);
    drive(1'b1, 4'b0000, AllW, 4'b0000, 1'b0);
    chk_out("post_reset", 4'b0000, 3'd7, 0, 0, 0);

    for (int i = 0; i < NVec; i++) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].addr, tbl[i].tail, tbl[i].ready);
      chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].xfer, tbl[i].rco,
              tbl[i].tmo);
    end

    // Timeout: e granted with the downstream stalled; l waits.
    reset_dut();
    drive(1'b1, 4'b1100, AllW, 4'b0000, 1'b0);
    chk_out("to_idle", 4'b0000, 3'd7, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'b1100, AllW, 4'b0000, 1'b0);
      chk_out($sformatf("to_hold%0d", k), 4'b0010, 3'd3, 0, 0, 0);
    end
    drive(1'b1, 4'b1100, AllW, 4'b0000, 1'b0);
    chk_out("to_fire", 4'b0000, 3'd7, 0, 1, 1);
    drive(1'b1, 4'b1100, AllW, 4'b0000, 1'b0);
    chk_out("to_next_l", 4'b0001, 3'd4, 0, 0, 0);

    // Body flit at the threshold cycle clears the counter.
    reset_dut();
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b0);
    chk_out("thr_idle", 4'b0000, 3'd7, 0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b0);
      chk_out($sformatf("thr_hold%0d", k), 4'b1000, 3'd0, 0, 0, 0);
    end
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
    chk_out("thr_body", 4'b1000, 3'd0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b0);
      chk_out($sformatf("thr_wait%0d", k), 4'b1000, 3'd0, 0, 0, 0);
    end
    drive(1'b1, 4'b0001, AllW, 4'b1111, 1'b1);
    chk_out("thr_tail", 4'b1000, 3'd0, 1, 0, 0);
    drive(1'b1, 4'b0000, AllW, 4'b0000, 1'b0);
    chk_out("thr_release", 4'b0000, 3'd7, 0, 1, 0);

    // Granted s drops valid mid-packet while n requests.
    reset_dut();
    drive(1'b1, 4'b0010, AllW, 4'b0000, 1'b1);
    chk_out("vd_idle", 4'b0000, 3'd7, 0, 0, 0);
    drive(1'b1, 4'b0011, AllW, 4'b0000, 1'b1);
    chk_out("vd_head", 4'b0100, 3'd1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
      chk_out($sformatf("vd_gap%0d", k), 4'b0100, 3'd1, 0, 0, 0);
    end
    drive(1'b1, 4'b0011, AllW, 4'b1111, 1'b1);
    chk_out("vd_tail", 4'b0100, 3'd1, 1, 0, 0);
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
    chk_out("vd_bubble", 4'b0000, 3'd7, 0, 1, 0);
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
    chk_out("vd_next_n", 4'b1000, 3'd0, 1, 0, 0);

    // Asynchronous reset while granted with hold_cnt at 5.
    reset_dut();
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b0);
    chk_out("ar_idle", 4'b0000, 3'd7, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b0);
      chk_out($sformatf("ar_hold%0d", k), 4'b1000, 3'd0, 0, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 4'b0000, 3'd7, 0, 0, 0);
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
    chk_out("ar_release", 4'b0000, 3'd7, 0, 0, 0);
    drive(1'b1, 4'b0001, AllW, 4'b0000, 1'b1);
    chk_out("ar_grant_n", 4'b1000, 3'd0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
